// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spikes and the first-spike latency over back-to-back
// windows of programmable length, publishing one result set per completed window.
module spike_rate_decoder #(
    parameter int WINDOW_W = 8,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                clear,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic                out_valid,
    output logic [COUNT_W-1:0]  count_out,
    output logic [WINDOW_W-1:0] latency_out,
    output logic                no_spike,
    output logic                saturated
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COUNT_W-1:0]  CNT_MAX = '1;
    localparam logic [WINDOW_W-1:0] T_ONE   = WINDOW_W'(1);

    state_t              state, state_nxt;
    logic [WINDOW_W-1:0] len_q, t_q, first_q;
    logic [COUNT_W-1:0]  cnt_q;
    logic                seen_q;

    logic                last, start, publish, abort;
    logic [COUNT_W-1:0]  cnt_nxt;
    logic [WINDOW_W-1:0] first_nxt;
    logic                seen_nxt;

    // Window state including this cycle's sample, used both to advance and to publish.
    assign last      = (t_q == len_q - T_ONE);
    assign cnt_nxt   = (spike_in && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    assign first_nxt = (spike_in && !seen_q) ? t_q : first_q;
    assign seen_nxt  = seen_q | spike_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        publish   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (ena && !clear && window_len != '0) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    // A completed window is always published, even if we stop afterwards.
                    publish = 1'b1;
                    if (!ena || window_len == '0) state_nxt = IDLE;
                end else if (!ena) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            t_q         <= '0;
            first_q     <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            out_valid   <= 1'b0;
            count_out   <= '0;
            latency_out <= '0;
            no_spike    <= 1'b0;
            saturated   <= 1'b0;
        end else if (clear) begin
            len_q       <= '0;
            t_q         <= '0;
            first_q     <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            out_valid   <= 1'b0;
            count_out   <= '0;
            latency_out <= '0;
            no_spike    <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start || publish || abort) begin
                len_q   <= window_len;
                t_q     <= '0;
                first_q <= '0;
                cnt_q   <= '0;
                seen_q  <= 1'b0;
            end else if (state == RUN) begin
                t_q     <= t_q + T_ONE;
                first_q <= first_nxt;
                cnt_q   <= cnt_nxt;
                seen_q  <= seen_nxt;
            end
            if (publish) begin
                out_valid   <= 1'b1;
                count_out   <= cnt_nxt;
                latency_out <= seen_nxt ? first_nxt : '0;
                no_spike    <= !seen_nxt;
                saturated   <= (cnt_nxt == CNT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: stimulus pushes expected window results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_spike_rate_decoder;

    localparam int WW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [WW-1:0] lat;
        logic          ns;
        logic          sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          clear = 1'b0;
    logic          spike_in = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic          out_valid;
    logic [CW-1:0] count_out;
    logic [WW-1:0] latency_out;
    logic          no_spike;
    logic          saturated;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    spike_rate_decoder #(.WINDOW_W(WW), .COUNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (clear),
        .spike_in   (spike_in),
        .window_len (window_len),
        .out_valid  (out_valid),
        .count_out  (count_out),
        .latency_out(latency_out),
        .no_spike   (no_spike),
        .saturated  (saturated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int c, input int l, input bit ns, input bit sat);
        exp_t e;
        e.cnt = CW'(c);
        e.lat = WW'(l);
        e.ns  = ns;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic s);
        spike_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int c, input int l, input int ns, input int sat);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_count"}, int'(count_out), c);
        chk({tag, "_latency"}, int'(latency_out), l);
        chk({tag, "_no_spike"}, int'(no_spike), ns);
        chk({tag, "_saturated"}, int'(saturated), sat);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_valid=1 count=%0d expected no result at %0t",
                         count_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("count", int'(count_out), int'(e.cnt));
                chk("latency", int'(latency_out), int'(e.lat));
                chk("no_spike", int'(no_spike), int'(e.ns));
                chk("saturated", int'(saturated), int'(e.sat));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_outs("reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0); cyc(0);

        // Basic window L=10, spikes at 3,5,9; stop on the final cycle.
        window_len = 10; ena = 1'b1;
        cyc(0);
        push(3, 3, 0, 0);
        for (int t = 0; t < 10; t++) begin
            if (t == 9) ena = 1'b0;
            cyc(t == 3 || t == 5 || t == 9);
        end
        cyc(0); cyc(0);

        // Back-to-back L=4, length changed to 2 mid-window.
        window_len = 4; ena = 1'b1;
        cyc(0);
        push(4, 0, 0, 0); push(4, 0, 0, 0);
        push(2, 0, 0, 0); push(2, 0, 0, 0); push(2, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            if (i == 5) window_len = 2;
            if (i == 13) ena = 1'b0;
            cyc(1);
        end
        cyc(0); cyc(0);

        // Empty window L=6, then L=1 with pattern 1,0,1.
        window_len = 6; ena = 1'b1;
        cyc(0);
        push(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) window_len = 1;
            cyc(0);
        end
        push(1, 0, 0, 0); push(0, 0, 1, 0); push(1, 0, 0, 0);
        cyc(1); cyc(0);
        ena = 1'b0;
        cyc(1);
        cyc(0); cyc(0);

        // Saturation: 20 spikes into a 4-bit counter.
        window_len = 20; ena = 1'b1;
        cyc(0);
        push(15, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 19) ena = 1'b0;
            cyc(1);
        end
        cyc(0); cyc(0);

        // ena dropped at t=5 of an L=10 window: results held, no pulse.
        window_len = 10; ena = 1'b1;
        cyc(0);
        for (int i = 0; i < 5; i++) cyc(i == 2);
        ena = 1'b0;
        cyc(1);
        cyc(0); cyc(0); cyc(0);
        chk_outs("abort_hold", 15, 0, 0, 1);

        // window_len=0 in IDLE: nothing starts.
        window_len = 0; ena = 1'b1;
        cyc(1); cyc(1); cyc(1);
        ena = 1'b0;
        chk_outs("len0_idle", 15, 0, 0, 1);

        // clear on the end-of-window cycle wins over publishing.
        window_len = 3; ena = 1'b1;
        cyc(0);
        cyc(0); cyc(1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0; ena = 1'b0;
        chk_outs("clear_end", 0, 0, 0, 0);
        cyc(0); cyc(0);

        // Re-latched window_len=0 at a boundary: publish, then stay IDLE.
        window_len = 2; ena = 1'b1;
        cyc(0);
        push(1, 0, 0, 0);
        window_len = 0;
        cyc(1); cyc(0);
        cyc(1); cyc(1); cyc(1);
        ena = 1'b0;
        cyc(0);
        chk_outs("len0_boundary", 1, 0, 0, 0);

        // Asynchronous reset mid-window with spikes active.
        window_len = 5; ena = 1'b1;
        cyc(0);
        cyc(1); cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_reset", 0, 0, 0, 0);
        ena = 1'b0; spike_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1); cyc(1); cyc(0);
        chk_outs("post_reset", 0, 0, 0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
